// File: rtl/ap_result_reader.sv
// Launches an associative-processor computation, waits for completion, then reads
// the result rows back one at a time and streams them out over a valid/ready port.
`timescale 1ns/1ps
module ap_result_reader #(
    parameter int WORD_SIZE   = 8,
    parameter int CELL_QUANT  = 512,
    parameter int ADDR_W      = $clog2(CELL_QUANT),
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    rd_count,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic                 ap_mode,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_read_en,
    output logic [ADDR_W-1:0]    ap_addr,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_state_irq,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    output logic [ADDR_W-1:0]    m_addr,
    output logic                 m_last
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        RD_REQ,
        RD_WAIT,
        OUT,
        FIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] last_row;
    logic [TW-1:0]     tmo_cnt;
    logic [LW-1:0]     lat_cnt;
    logic              tmo_hit;
    logic              lat_done;

    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign lat_done = (lat_cnt == LW'(RD_LAT - 1));

    assign busy       = (state != IDLE);
    assign done       = (state == FIN);
    assign ap_mode    = (state == RUN);
    assign ap_read_en = (state == RD_REQ);
    assign ap_sel_col = (state == RD_REQ || state == RD_WAIT) ? 2'd2 : 2'd0;
    assign ap_addr    = row;
    assign m_valid    = (state == OUT);

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            // A completion seen in the same cycle as the timeout still counts as success.
            RUN: begin
                if (ap_state_irq) begin
                    state_next = RD_REQ;
                end else if (tmo_hit) begin
                    state_next = FIN;
                end
            end
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: if (lat_done) state_next = OUT;
            OUT: begin
                if (m_ready) begin
                    state_next = m_last ? FIN : RD_REQ;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            row         <= '0;
            last_row    <= '0;
            tmo_cnt     <= '0;
            lat_cnt     <= '0;
            timeout_err <= 1'b0;
            m_data      <= '0;
            m_addr      <= '0;
            m_last      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // Storing the final row index keeps a count of 0 (full array) in ADDR_W bits.
                        last_row    <= (rd_count == '0) ? ADDR_W'(CELL_QUANT - 1)
                                                        : rd_count - ADDR_W'(1);
                        timeout_err <= 1'b0;
                        tmo_cnt     <= '0;
                        row         <= '0;
                    end
                end
                RUN: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (ap_state_irq) begin
                        row <= '0;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                RD_REQ: lat_cnt <= '0;
                RD_WAIT: begin
                    lat_cnt <= lat_cnt + LW'(1);
                    if (lat_done) begin
                        m_data <= ap_data_out;
                        m_addr <= row;
                        m_last <= (row == last_row);
                    end
                end
                OUT: begin
                    if (m_ready && !m_last) begin
                        row <= row + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
